// File: rtl/deser_pkg.sv
// Shared types for the serial deserializer: collection FSM states and count width.
// DESER_PARITY_EN adds the PARITY state used by the optional even-parity bit.
package deser_pkg;

`ifdef DESER_PARITY_EN
  typedef enum logic {ST_DATA = 1'b0, ST_PARITY = 1'b1} deser_state_t;
`else
  typedef enum logic {ST_DATA = 1'b0} deser_state_t;
`endif

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_shift.sv
// Collection shift register; par_next is the value after shifting in bit_in,
// so a completing bit can be captured in the same edge it arrives.
module deser_shift #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             bit_in,
  output logic [WIDTH-1:0] par_out,
  output logic [WIDTH-1:0] par_next
);

  generate
    if (MSB_FIRST) begin : g_msb
      assign par_next = {par_out[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign par_next = {bit_in, par_out[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)      par_out <= '0;
    else if (clear)    par_out <= '0;
    else if (shift_en) par_out <= par_next;
  end

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with one-word output buffer and sticky overflow.
// Define DESER_PARITY_EN to append an even-parity bit per word and flag errors.
module serial_deser
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     bit_valid_in,
  input  logic                     bit_in,
  input  logic                     clear_in,
  input  logic                     data_ready_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid_out,
  output logic [cnt_w(WIDTH)-1:0]  bit_count_out,
  output logic                     overflow_out
`ifdef DESER_PARITY_EN
  ,
  output logic                     parity_err_out
`endif
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  deser_state_t     state_q, state_d;
  logic             accept, shift_en, word_done, take, load;
  logic [WIDTH-1:0] sh_q, sh_next, word;
`ifdef DESER_PARITY_EN
  logic             word_par;
`endif

  // clear beats a coincident bit
  assign accept = bit_valid_in & ~clear_in;
  assign take   = data_valid_out & data_ready_in;
  assign load   = word_done & (~data_valid_out | take);

  deser_shift #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .shift_en (shift_en),
    .clear    (clear_in | word_done),
    .bit_in   (bit_in),
    .par_out  (sh_q),
    .par_next (sh_next)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)      state_q <= ST_DATA;
    else if (clear_in) state_q <= ST_DATA;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef DESER_PARITY_EN
    case (state_q)
      ST_DATA:   if (accept && bit_count_out == LAST) state_d = ST_PARITY;
      ST_PARITY: if (accept) state_d = ST_DATA;
      default:   state_d = ST_DATA;
    endcase
`endif
  end

  always_comb begin
    shift_en  = 1'b0;
    word_done = 1'b0;
    word      = sh_next;
`ifdef DESER_PARITY_EN
    word_par  = 1'b0;
    case (state_q)
      ST_PARITY: begin
        word_done = accept;
        word      = sh_q;
        word_par  = ^{sh_q, bit_in};
      end
      default: shift_en = accept;
    endcase
`else
    shift_en  = accept;
    word_done = accept && (bit_count_out == LAST);
`endif
  end

  // count parks at WIDTH while the parity bit is awaited
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)       bit_count_out <= '0;
    else if (clear_in)  bit_count_out <= '0;
    else if (word_done) bit_count_out <= '0;
    else if (shift_en)  bit_count_out <= bit_count_out + 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else if (load) begin
      data_out       <= word;
      data_valid_out <= 1'b1;
    end else if (take) begin
      data_valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)                overflow_out <= 1'b0;
    else if (clear_in)           overflow_out <= 1'b0;
    else if (word_done && !load) overflow_out <= 1'b1;
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)  parity_err_out <= 1'b0;
    else if (load) parity_err_out <= word_par;
  end
`endif

endmodule
